// File: rtl/boruss_ram_sp.sv
// Single-port synchronous RAM for the Borus CPU data/stack space.
// Valid/ready request port, registered read responses with one cycle of
// latency, out-of-range detection, and a clear sweep that writes INIT_VALUE
// to every word after reset and whenever clear_req is seen in service.
module boruss_ram_sp #(
  parameter int unsigned           DATA_WIDTH = 8,
  parameter int unsigned           ADDR_WIDTH = 8,
  parameter int unsigned           DEPTH      = 256,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic                  clear_req,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  init_done
);

  // Index width that exactly covers the array; DEPTH <= 2**ADDR_WIDTH keeps it
  // no wider than the address bus.
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Range limits kept one bit wider than the address so DEPTH == 2**ADDR_WIDTH
  // is representable and the sweep ends without wrapping.
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] LAST_W  = (ADDR_WIDTH+1)'(DEPTH - 1);

  typedef enum logic {
    ST_INIT,
    ST_READY
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH:0]   cnt;

  logic                  accept;
  logic                  rd_accept;
  logic                  in_range;
  logic                  sweep_last;

  logic                  mem_we;
  logic [IDX_W-1:0]      mem_widx;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [IDX_W-1:0]      req_idx;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign in_range   = {1'b0, req_addr} < DEPTH_W;
  assign accept     = req_valid && req_ready;
  assign rd_accept  = accept && !req_write;
  assign sweep_last = (cnt == LAST_W);
  assign req_idx    = req_addr[IDX_W-1:0];

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_INIT;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: sweep until the last word, leave service on clear_req.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_INIT:  if (sweep_last) state_next = ST_READY;
      ST_READY: if (clear_req)  state_next = ST_INIT;
      default:  state_next = ST_INIT;
    endcase
  end

  // Output decode; both flags depend only on the state register.
  always_comb begin
    req_ready = 1'b0;
    init_done = 1'b0;
    if (state == ST_READY) begin
      req_ready = 1'b1;
      init_done = 1'b1;
    end
  end

  // Sweep counter: advances only while clearing, parked at zero otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (state == ST_INIT) begin
      cnt <= sweep_last ? '0 : cnt + 1'b1;
    end else begin
      cnt <= '0;
    end
  end

  // Single write port shared between the clear sweep and accepted writes.
  always_comb begin
    mem_we    = 1'b0;
    mem_widx  = req_idx;
    mem_wdata = req_wdata;
    if (state == ST_INIT) begin
      mem_we    = 1'b1;
      mem_widx  = cnt[IDX_W-1:0];
      mem_wdata = INIT_VALUE;
    end else if (accept && req_write && in_range) begin
      mem_we = 1'b1;
    end
  end

  // Storage array; contents are deliberately not reset, the sweep clears them.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_widx] <= mem_wdata;
    end
  end

  // Registered response: one-cycle pulses, read data held between responses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= rd_accept;
      resp_err   <= accept && !in_range;
      if (rd_accept) begin
        resp_rdata <= in_range ? mem[req_idx] : '0;
      end
    end
  end

endmodule

// File: tb/tb_boruss_ram_sp.sv
// Directed testbench for boruss_ram_sp: a full-depth instance (256 words,
// clear value 0x3C) and a partial-depth instance (200 words, clear value 0)
// for the out-of-range cases. Inputs change and outputs are sampled on the
// falling clock edge.
module tb_boruss_ram_sp;

  localparam int unsigned A_DEPTH = 256;
  localparam int unsigned B_DEPTH = 200;
  localparam logic [7:0]  A_INIT  = 8'h3C;

  logic       clk;
  logic       reset_n;

  logic       a_req_valid, a_req_ready, a_req_write, a_clear_req;
  logic [7:0] a_req_addr, a_req_wdata, a_resp_rdata;
  logic       a_resp_valid, a_resp_err, a_init_done;

  logic       b_req_valid, b_req_ready, b_req_write, b_clear_req;
  logic [7:0] b_req_addr, b_req_wdata, b_resp_rdata;
  logic       b_resp_valid, b_resp_err, b_init_done;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned n;

  boruss_ram_sp #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(8),
    .DEPTH     (A_DEPTH),
    .INIT_VALUE(A_INIT)
  ) dut_a (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (a_req_valid),
    .req_ready (a_req_ready),
    .req_write (a_req_write),
    .req_addr  (a_req_addr),
    .req_wdata (a_req_wdata),
    .clear_req (a_clear_req),
    .resp_valid(a_resp_valid),
    .resp_rdata(a_resp_rdata),
    .resp_err  (a_resp_err),
    .init_done (a_init_done)
  );

  boruss_ram_sp #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(8),
    .DEPTH     (B_DEPTH),
    .INIT_VALUE(8'h00)
  ) dut_b (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (b_req_valid),
    .req_ready (b_req_ready),
    .req_write (b_req_write),
    .req_addr  (b_req_addr),
    .req_wdata (b_req_wdata),
    .clear_req (b_clear_req),
    .resp_valid(b_resp_valid),
    .resp_rdata(b_resp_rdata),
    .resp_err  (b_resp_err),
    .init_done (b_init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Present one request to instance A for a single cycle.
  task automatic a_req(input logic wr, input logic [7:0] addr, input logic [7:0] data);
    a_req_valid = 1'b1;
    a_req_write = wr;
    a_req_addr  = addr;
    a_req_wdata = data;
    @(negedge clk);
    a_req_valid = 1'b0;
    a_req_write = 1'b0;
  endtask

  task automatic b_req(input logic wr, input logic [7:0] addr, input logic [7:0] data);
    b_req_valid = 1'b1;
    b_req_write = wr;
    b_req_addr  = addr;
    b_req_wdata = data;
    @(negedge clk);
    b_req_valid = 1'b0;
    b_req_write = 1'b0;
  endtask

  // Read on A and check the response that is visible one cycle later.
  task automatic a_read_check(input string tag, input logic [7:0] addr, input logic [7:0] exp);
    a_req(1'b0, addr, 8'h00);
    check({tag, "_valid"}, a_resp_valid, 1);
    check({tag, "_data"},  a_resp_rdata, exp);
    check({tag, "_err"},   a_resp_err,   0);
  endtask

  // Count cycles with init_done low on A, starting at the current cycle;
  // pulses clear_req once mid-sweep, which must not restart the sweep.
  task automatic a_count_sweep(output int unsigned cycles);
    cycles = 0;
    while (!a_init_done && cycles < 1000) begin
      cycles++;
      a_clear_req = (cycles == 50);
      @(negedge clk);
    end
    a_clear_req = 1'b0;
  endtask

  initial begin
    reset_n     = 1'b0;
    a_req_valid = 1'b0; a_req_write = 1'b0; a_req_addr = '0; a_req_wdata = '0; a_clear_req = 1'b0;
    b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_clear_req = 1'b0;

    // 1: reset state, sweep length, cleared contents
    repeat (3) @(negedge clk);
    check("rst_ready", a_req_ready,  0);
    check("rst_valid", a_resp_valid, 0);
    check("rst_rdata", a_resp_rdata, 0);
    check("rst_err",   a_resp_err,   0);
    check("rst_done",  a_init_done,  0);
    reset_n = 1'b1;
    a_count_sweep(n);
    check("init_cycles", n, A_DEPTH);
    check("init_ready",  a_req_ready, 1);
    a_read_check("rd_00", 8'h00, A_INIT);
    a_read_check("rd_ff", 8'hFF, A_INIT);

    // 2: write followed immediately by read of the same address
    a_req(1'b1, 8'h10, 8'hA5);
    check("wr_novalid", a_resp_valid, 0);
    a_read_check("rd_10", 8'h10, 8'hA5);

    // 3: back-to-back reads
    a_req(1'b1, 8'h01, 8'h11);
    a_req(1'b1, 8'h02, 8'h22);
    a_req(1'b1, 8'h03, 8'h33);
    a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = 8'h01;
    @(negedge clk);
    check("b2b1_valid", a_resp_valid, 1);
    check("b2b1_data",  a_resp_rdata, 8'h11);
    a_req_addr = 8'h02;
    @(negedge clk);
    check("b2b2_valid", a_resp_valid, 1);
    check("b2b2_data",  a_resp_rdata, 8'h22);
    a_req_addr = 8'h03;
    @(negedge clk);
    check("b2b3_valid", a_resp_valid, 1);
    check("b2b3_data",  a_resp_rdata, 8'h33);
    a_req_valid = 1'b0;
    @(negedge clk);
    check("b2b_end_valid", a_resp_valid, 0);
    check("b2b_hold_data", a_resp_rdata, 8'h33);

    // 5: clear with a same-cycle write; the sweep overwrites it
    a_clear_req = 1'b1;
    a_req(1'b1, 8'h05, 8'h77);
    a_clear_req = 1'b0;
    check("clr_ready_drop", a_req_ready, 0);
    check("clr_done_drop",  a_init_done, 0);
    a_count_sweep(n);
    check("clr_cycles", n, A_DEPTH);
    a_read_check("clr_rd_05", 8'h05, A_INIT);
    a_read_check("clr_rd_10", 8'h10, A_INIT);

    // 6: reset right after a read is accepted discards its response
    a_req(1'b1, 8'h00, 8'h99);
    a_read_check("pre_rst_00", 8'h00, 8'h99);
    a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = 8'h00;
    @(posedge clk);
    #1;
    reset_n     = 1'b0;
    a_req_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_valid", a_resp_valid, 0);
    check("rst_mid_rdata", a_resp_rdata, 0);
    check("rst_mid_done",  a_init_done,  0);
    reset_n = 1'b1;
    a_count_sweep(n);
    check("rst_mid_cycles", n, A_DEPTH);
    a_read_check("rst_mid_rd_00", 8'h00, A_INIT);

    // 4: partial-depth instance, out-of-range accesses
    check("b_done", b_init_done, 1);
    b_req(1'b1, 8'hC7, 8'h12);
    check("b_wr_c7_err", b_resp_err, 0);
    b_req(1'b1, 8'hC8, 8'h5A);
    check("b_wr_c8_err",   b_resp_err,   1);
    check("b_wr_c8_valid", b_resp_valid, 0);
    b_req(1'b0, 8'hC8, 8'h00);
    check("b_rd_c8_valid", b_resp_valid, 1);
    check("b_rd_c8_data",  b_resp_rdata, 8'h00);
    check("b_rd_c8_err",   b_resp_err,   1);
    b_req(1'b0, 8'hC7, 8'h00);
    check("b_rd_c7_valid", b_resp_valid, 1);
    check("b_rd_c7_data",  b_resp_rdata, 8'h12);
    check("b_rd_c7_err",   b_resp_err,   0);
    b_req(1'b0, 8'h48, 8'h00);
    check("b_rd_48_data",  b_resp_rdata, 8'h00);
    check("b_rd_48_err",   b_resp_err,   0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

endmodule
